deslocamento_direita_seq: RTL and testbench

- Multi-cycle right shifter for the processor datapath.
- Shifts one bit per clock. Supports logical shift (zero fill) and arithmetic shift (sign fill).
- Uses a start/done handshake. Companion of the combinational left shift unit; serves SRL/SRA-class instructions in the execute stage, where the control unit stalls until `pronto`.

---
 rtl/deslocamento_direita_seq.sv | 113 +++++++++++
 tb/tb_deslocamento_direita_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/deslocamento_direita_seq.sv
// Multi-cycle right shifter (SRL/SRA): shifts one bit per clock behind an inicio/pronto handshake.
// Operands are captured on start, so the execute stage may change its inputs while the unit is busy.
module deslocamento_direita_seq #(
    parameter int LARGURA  = 32,
    parameter int BITS_QTD = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inicio,
    input  logic [LARGURA-1:0]  sinal_original,
    input  logic [BITS_QTD-1:0] quantidade,
    input  logic                aritmetico,
    output logic [LARGURA-1:0]  sinal_deslocado,
    output logic                bit_perdido,
    output logic                ocupado,
    output logic                pronto
);

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        DESLOCANDO = 2'd1,
        CONCLUIDO  = 2'd2
    } estado_t;

    localparam logic [BITS_QTD-1:0] QTD_ZERO = BITS_QTD'(0);
    localparam logic [BITS_QTD-1:0] QTD_UM   = BITS_QTD'(1);

    estado_t               r_estado;
    logic [LARGURA-1:0]    r_trabalho;
    logic [BITS_QTD-1:0]   r_contador;
    logic                  r_aritmetico;
    logic [LARGURA-1:0]    r_saida;
    logic                  r_bit;
    logic                  r_ocupado;
    logic                  r_pronto;

    logic                  w_preenche;
    logic [LARGURA-1:0]    w_deslocado;

    // Fill bit is the captured sign only in arithmetic mode.
    assign w_preenche  = r_aritmetico & r_trabalho[LARGURA-1];
    assign w_deslocado = {w_preenche, r_trabalho[LARGURA-1:1]};

    // Control FSM with datapath; outputs are registered and only updated on completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado     <= OCIOSO;
            r_trabalho   <= '0;
            r_contador   <= QTD_ZERO;
            r_aritmetico <= 1'b0;
            r_saida      <= '0;
            r_bit        <= 1'b0;
            r_ocupado    <= 1'b0;
            r_pronto     <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_pronto <= 1'b0;
                    if (inicio) begin
                        r_trabalho   <= sinal_original;
                        r_contador   <= quantidade;
                        r_aritmetico <= aritmetico;
                        if (quantidade == QTD_ZERO) begin
                            r_estado  <= CONCLUIDO;
                            r_saida   <= sinal_original;
                            r_bit     <= 1'b0;
                            r_ocupado <= 1'b0;
                            r_pronto  <= 1'b1;
                        end else begin
                            r_estado  <= DESLOCANDO;
                            r_ocupado <= 1'b1;
                        end
                    end else begin
                        r_estado  <= OCIOSO;
                        r_ocupado <= 1'b0;
                    end
                end
                DESLOCANDO: begin
                    r_trabalho <= w_deslocado;
                    r_contador <= r_contador - QTD_UM;
                    if (r_contador == QTD_UM) begin
                        r_saida   <= w_deslocado;
                        r_bit     <= r_trabalho[0];
                        r_estado  <= CONCLUIDO;
                        r_ocupado <= 1'b0;
                        r_pronto  <= 1'b1;
                    end else begin
                        r_estado  <= DESLOCANDO;
                        r_ocupado <= 1'b1;
                        r_pronto  <= 1'b0;
                    end
                end
                CONCLUIDO: begin
                    // inicio is deliberately ignored here; a new start is taken in OCIOSO.
                    r_estado  <= OCIOSO;
                    r_ocupado <= 1'b0;
                    r_pronto  <= 1'b0;
                end
                default: begin
                    r_estado  <= OCIOSO;
                    r_ocupado <= 1'b0;
                    r_pronto  <= 1'b0;
                end
            endcase
        end
    end

    assign sinal_deslocado = r_saida;
    assign bit_perdido     = r_bit;
    assign ocupado         = r_ocupado;
    assign pronto          = r_pronto;

endmodule

// File: tb/tb_deslocamento_direita_seq.sv
// Directed bench for deslocamento_direita_seq: hand-computed vectors checked with immediate assertions.
module tb_deslocamento_direita_seq;

    logic        clock;
    logic        reset;
    logic        inicio;
    logic [31:0] sinal_original;
    logic [4:0]  quantidade;
    logic        aritmetico;
    logic [31:0] sinal_deslocado;
    logic        bit_perdido;
    logic        ocupado;
    logic        pronto;

    int vectors     = 0;
    int miscompares = 0;

    deslocamento_direita_seq #(.LARGURA(32), .BITS_QTD(5)) dut (
        .clock           (clock),
        .reset           (reset),
        .inicio          (inicio),
        .sinal_original  (sinal_original),
        .quantidade      (quantidade),
        .aritmetico      (aritmetico),
        .sinal_deslocado (sinal_deslocado),
        .bit_perdido     (bit_perdido),
        .ocupado         (ocupado),
        .pronto          (pronto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] val, input logic [4:0] n, input logic arit);
        sinal_original = val;
        quantidade     = n;
        aritmetico     = arit;
        inicio         = 1'b1;
        tick();
        inicio         = 1'b0;
    endtask

    // Waits for pronto; n is the number of edges still expected before the pulse.
    task automatic wait_done(input string tag, input int n, input logic [31:0] exp_val, input logic exp_bit);
        int cyc = 0;
        if (n != 0) check({tag, "_busy"}, {31'd0, ocupado}, 32'd1);
        while (pronto !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, n);
        check({tag, "_pronto"}, {31'd0, pronto}, 32'd1);
        check({tag, "_ocupado_done"}, {31'd0, ocupado}, 32'd0);
        check({tag, "_value"}, sinal_deslocado, exp_val);
        check({tag, "_bit"}, {31'd0, bit_perdido}, {31'd0, exp_bit});
        tick();
        check({tag, "_pulse_end"}, {31'd0, pronto}, 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        inicio         = 1'b0;
        sinal_original = 32'h0;
        quantidade     = 5'd0;
        aritmetico     = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state held while idle.
        for (int i = 0; i < 10; i++) begin
            check("idle_value", sinal_deslocado, 32'h0);
            check("idle_flags", {28'd0, bit_perdido, ocupado, pronto, 1'b0}, 32'h0);
            tick();
        end

        start(32'h0000_0008, 5'd2, 1'b0);
        wait_done("srl_8_2", 2, 32'h0000_0002, 1'b0);

        start(32'hF000_0001, 5'd4, 1'b1);
        wait_done("sra_f0_4", 4, 32'hFF00_0000, 1'b0);

        start(32'hF000_0001, 5'd4, 1'b0);
        wait_done("srl_f0_4", 4, 32'h0F00_0000, 1'b0);

        start(32'h1234_5678, 5'd0, 1'b0);
        wait_done("zero_amt", 0, 32'h1234_5678, 1'b0);

        start(32'h8000_0000, 5'd31, 1'b1);
        wait_done("sra_max", 31, 32'hFFFF_FFFF, 1'b0);

        start(32'h8000_0000, 5'd31, 1'b0);
        wait_done("srl_max", 31, 32'h0000_0001, 1'b0);

        start(32'h0000_0003, 5'd1, 1'b0);
        wait_done("srl_3_1", 1, 32'h0000_0001, 1'b1);

        // Operands changed and inicio pulsed mid-operation must be ignored.
        start(32'h0000_0100, 5'd8, 1'b0);
        tick();
        tick();
        tick();
        sinal_original = 32'hFFFF_FFFF;
        quantidade     = 5'd3;
        aritmetico     = 1'b1;
        inicio         = 1'b1;
        tick();
        inicio         = 1'b0;
        wait_done("stable", 4, 32'h0000_0001, 1'b0);
        for (int i = 0; i < 12; i++) begin
            check("stable_no_restart", {30'd0, ocupado, pronto}, 32'd0);
            tick();
        end

        // Reset in the middle of an operation aborts it.
        start(32'hDEAD_BEEF, 5'd20, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_value", sinal_deslocado, 32'h0);
        check("abort_flags", {29'd0, bit_perdido, ocupado, pronto}, 32'h0);
        for (int i = 0; i < 25; i++) begin
            check("abort_no_pronto", {31'd0, pronto}, 32'd0);
            tick();
        end

        // Reset wins over a simultaneous start.
        sinal_original = 32'h0000_00FF;
        quantidade     = 5'd0;
        reset          = 1'b1;
        inicio         = 1'b1;
        tick();
        reset          = 1'b0;
        inicio         = 1'b0;
        check("rst_vs_start_value", sinal_deslocado, 32'h0);
        check("rst_vs_start_flags", {30'd0, ocupado, pronto}, 32'h0);

        // Start on the first edge after reset deasserts is accepted.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start(32'h0000_0010, 5'd4, 1'b0);
        wait_done("after_reset", 4, 32'h0000_0001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
